// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if
//   Bundles the two handshakes of the fetch front end:
//   - instruction memory bus (req/addr out, ack/rdata back)
//   - decode-side queue head (valid/instr/pc/pc+4 out, ready back)
//   The master modport is the fetch queue; the slave modport is the
//   memory plus the decode stage.
interface instr_fetch_queue_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc_plus4_o;
  logic        instr_ready_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_ack_i, mem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
    input  instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_ack_i, mem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o, instr_pc_plus4_o,
    output instr_ready_i
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch front end for the single-cycle core. Issues sequential word
//   fetches over a req/ack memory bus, buffers up to DEPTH instructions
//   (instruction, PC, PC+4) in a circular queue, and hands them to decode
//   with a valid/ready handshake. A redirect flushes the queue and
//   restarts fetching at the new (word-aligned) target.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   redirect_i     taken branch / j / jal / jr from the core
//   redirect_pc_i  new fetch address (low two bits ignored)
//   bus            instr_fetch_queue_if.master: memory req/ack bus and
//                  decode-side valid/ready head
//   count_o        number of occupied entries
//
// Configuration
//   IFQ_BYPASS_EN  when defined, an ack arriving while the queue is empty
//                  is presented to decode in the same cycle (and consumed
//                  without being written if decode is ready). When
//                  undefined, there is no combinational path from the
//                  memory bus to the instruction outputs.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  instr_fetch_queue_if.master      bus,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_plus4;
  logic [31:0]      drain_addr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] pc4_mem   [DEPTH];

  logic ack_ok;
  logic push;
  logic pop;
  logic space_left;

  assign fetch_pc_plus4 = fetch_pc + 32'd4;

  // An ack only delivers a usable word in REQ; in DRAIN it belongs to a
  // request made before a redirect, and a same-cycle redirect kills it.
  assign ack_ok = (state == ST_REQ) && bus.mem_ack_i && !redirect_i;
  assign pop    = (count != '0) && bus.instr_ready_i;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass = ack_ok && (count == '0);
  // A bypassed word taken by decode in the same cycle never enters storage.
  assign push   = ack_ok && !(bypass && bus.instr_ready_i);
`else
  assign push   = ack_ok;
`endif

  assign count_after = count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  assign space_left  = count_after < CNT_W'(DEPTH);

  // Head outputs come straight from the rd_ptr slot and read zero while
  // the queue is empty.
  always_comb begin
    bus.instr_valid_o    = (count != '0);
    bus.instr_o          = '0;
    bus.instr_pc_o       = '0;
    bus.instr_pc_plus4_o = '0;
    if (count != '0) begin
      bus.instr_o          = instr_mem[rd_ptr];
      bus.instr_pc_o       = pc_mem[rd_ptr];
      bus.instr_pc_plus4_o = pc4_mem[rd_ptr];
    end
`ifdef IFQ_BYPASS_EN
    if (bypass) begin
      bus.instr_valid_o    = 1'b1;
      bus.instr_o          = bus.mem_rdata_i;
      bus.instr_pc_o       = fetch_pc;
      bus.instr_pc_plus4_o = fetch_pc_plus4;
    end
`endif
  end

  // DRAIN keeps presenting the pre-redirect address because an issued
  // request cannot be withdrawn; REQ and IDLE show the live fetch_pc.
  assign bus.mem_req_o  = (state != ST_IDLE);
  assign bus.mem_addr_o = (state == ST_DRAIN) ? drain_addr : fetch_pc;
  assign count_o        = count;

  // Next-state logic. A request is only issued when an entry is
  // guaranteed for it: REQ is entered or kept only if the queue has room
  // after this cycle's push/pop, and while in REQ the count can only fall.
  // A redirect that coincides with the ack of a draining request lets
  // the redirected fetch start right away instead of re-draining.
  always_comb begin
    state_next = state;
    if (redirect_i) begin
      case (state)
        ST_IDLE:  state_next = ST_REQ;
        ST_REQ:   state_next = bus.mem_ack_i ? ST_REQ : ST_DRAIN;
        ST_DRAIN: state_next = bus.mem_ack_i ? ST_REQ : ST_DRAIN;
        default:  state_next = ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE:  if (space_left) state_next = ST_REQ;
        ST_REQ:   if (bus.mem_ack_i) state_next = space_left ? ST_REQ : ST_IDLE;
        ST_DRAIN: if (bus.mem_ack_i) state_next = ST_REQ;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Control state: FSM, fetch address, pointers and occupancy. Reset
  // beats redirect, which beats normal push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      fetch_pc   <= RESET_PC & ~32'h3;
      drain_addr <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i & ~32'h3;
        rd_ptr   <= wr_ptr;
        count    <= '0;
        if ((state == ST_REQ) && !bus.mem_ack_i) begin
          drain_addr <= fetch_pc;
        end
      end else begin
        if (ack_ok) begin
          fetch_pc <= fetch_pc_plus4;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count_after;
      end
    end
  end

  // Queue storage; contents need no reset because count gates the head.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      instr_mem[wr_ptr] <= bus.mem_rdata_i;
      pc_mem[wr_ptr]    <= fetch_pc;
      pc4_mem[wr_ptr]   <= fetch_pc_plus4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Drives instr_fetch_queue with a programmable-latency memory model and
//   a decode-side ready. Expected instructions are queued when the memory
//   acks and compared against the queue head every cycle.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    redirect;
  logic [31:0]             redirect_pc;
  logic [$clog2(DEPTH):0]  count;

  instr_fetch_queue_if bus_if ();

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .bus           (bus_if),
    .count_o       (count)
  );

  int     checks   = 0;
  int     failures = 0;
  entry_t sb[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_drain_addr;
  bit     in_drain;
  int     ack_delay;
  int     req_age;
  int     acks_seen;

  // Deterministic instruction word per address, so stale data is visible.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs n cycles: memory answers at the negedge, outputs are checked
  // against the scoreboard, then the model advances for the coming edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      entry_t head_e;
      entry_t push_e;
      bit req, ack, exp_valid, byp, do_pop, do_push;
      @(negedge clk);
      req = bus_if.mem_req_o;
      ack = req && (req_age >= ack_delay);
      bus_if.mem_ack_i   = ack;
      bus_if.mem_rdata_i = ack ? memWord(bus_if.mem_addr_o) : $urandom;
      #1;
      push_e    = '{memWord(exp_pc), exp_pc, exp_pc + 32'd4};
      byp       = BYPASS && req && ack && !in_drain && !redirect && (sb.size() == 0);
      exp_valid = (sb.size() != 0) || byp;
      if (sb.size() != 0) head_e = sb[0];
      else if (byp)       head_e = push_e;
      else                head_e = '0;
      if (req) checkOutput("mem_addr", bus_if.mem_addr_o, in_drain ? exp_drain_addr : exp_pc);
      checkOutput("count", 32'(count), 32'(sb.size()));
      checkOutput("instr_valid", 32'(bus_if.instr_valid_o), 32'(exp_valid));
      checkOutput("instr", bus_if.instr_o, head_e.instr);
      checkOutput("instr_pc", bus_if.instr_pc_o, head_e.pc);
      checkOutput("instr_pc_plus4", bus_if.instr_pc_plus4_o, head_e.pc4);
      if (sb.size() == DEPTH) checkOutput("req_when_full", 32'(req), 32'd0);

      if (rst) begin
        sb.delete();
        exp_pc   = 32'h0;
        in_drain = 1'b0;
      end else if (redirect) begin
        sb.delete();
        if (req && !ack && !in_drain) begin
          in_drain       = 1'b1;
          exp_drain_addr = exp_pc;
        end else if (ack) begin
          in_drain = 1'b0;
        end
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        do_pop  = exp_valid && bus_if.instr_ready_i;
        do_push = req && ack && !in_drain;
        if (do_pop && sb.size() != 0) void'(sb.pop_front());
        else if (do_pop)              do_push = 1'b0;
        if (do_push) sb.push_back(push_e);
        if (req && ack) begin
          if (in_drain) in_drain = 1'b0;
          else          exp_pc = exp_pc + 32'd4;
        end
      end
      if (ack) acks_seen++;
      req_age = (req && !ack) ? req_age + 1 : 0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitReq(input string tag);
    for (int k = 0; k < 20 && !bus_if.mem_req_o; k++) applyStimulus(1);
    checkOutput(tag, 32'(bus_if.mem_req_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    bus_if.mem_ack_i = 1'b0; bus_if.mem_rdata_i = '0; bus_if.instr_ready_i = 1'b0;
    exp_pc = '0; exp_drain_addr = '0; in_drain = 1'b0;
    ack_delay = 2; req_age = 0; acks_seen = 0;

    // Reset state, then first fetch with a two-cycle memory.
    @(posedge clk); #1;
    applyStimulus(1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(bus_if.instr_valid_o), 32'd0);
    checkOutput("rst_req", 32'(bus_if.mem_req_o), 32'd0);
    checkOutput("rst_instr", bus_if.instr_o, 32'd0);
    checkOutput("rst_pc", bus_if.instr_pc_o, 32'd0);
    checkOutput("rst_pc4", bus_if.instr_pc_plus4_o, 32'd0);
    rst = 1'b0;
    acks_seen = 0;
    waitReq("first_req");
    checkOutput("first_addr", bus_if.mem_addr_o, 32'h0);
    for (int k = 0; k < 20 && acks_seen < 1; k++) applyStimulus(1);
    checkOutput("first_ack_seen", 32'(acks_seen), 32'd1);
    checkOutput("first_valid", 32'(bus_if.instr_valid_o), 32'd1);
    checkOutput("first_pc", bus_if.instr_pc_o, 32'h0);
    checkOutput("first_pc4", bus_if.instr_pc_plus4_o, 32'h4);

    // Ack every cycle with decode stalled: exactly four fetches fill it.
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    ack_delay = 0; acks_seen = 0;
    applyStimulus(12);
    checkOutput("fill_acks", 32'(acks_seen), 32'd4);
    checkOutput("fill_req", 32'(bus_if.mem_req_o), 32'd0);
    checkOutput("fill_count", 32'(count), 32'd4);
    bus_if.instr_ready_i = 1'b1; applyStimulus(1); bus_if.instr_ready_i = 1'b0;
    checkOutput("refetch_req", 32'(bus_if.mem_req_o), 32'd1);
    checkOutput("refetch_addr", bus_if.mem_addr_o, 32'h10);

    // Push and pop in the same cycle keep occupancy and order.
    bus_if.instr_ready_i = 1'b1;
    applyStimulus(1);
    checkOutput("pushpop_count", 32'(count), 32'd3);
    applyStimulus(8);
    checkOutput("pushpop_count_steady", 32'(count), 32'd3);
    bus_if.instr_ready_i = 1'b0;
    applyStimulus(4);
    checkOutput("refill_count", 32'(count), 32'd4);
    checkOutput("refill_req", 32'(bus_if.mem_req_o), 32'd0);

    // Redirect while the request to 0x8 is still outstanding.
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    ack_delay = 3; bus_if.instr_ready_i = 1'b1;
    for (int k = 0; k < 40 && !(bus_if.mem_req_o && exp_pc == 32'h8 && !in_drain); k++) applyStimulus(1);
    checkOutput("reach_0x8", bus_if.mem_addr_o, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h0000_0103; applyStimulus(1); redirect = 1'b0;
    bus_if.instr_ready_i = 1'b0;
    checkOutput("drain_req", 32'(bus_if.mem_req_o), 32'd1);
    checkOutput("drain_addr", bus_if.mem_addr_o, 32'h8);
    checkOutput("drain_count", 32'(count), 32'd0);
    for (int k = 0; k < 10 && !(bus_if.mem_req_o && bus_if.mem_addr_o == 32'h100); k++) applyStimulus(1);
    checkOutput("redirect_addr", bus_if.mem_addr_o, 32'h100);
    for (int k = 0; k < 10 && !bus_if.instr_valid_o; k++) applyStimulus(1);
    checkOutput("redirect_head_pc", bus_if.instr_pc_o, 32'h100);
    checkOutput("redirect_head_pc4", bus_if.instr_pc_plus4_o, 32'h104);

    // Redirect coinciding with an ack: data dropped, new address next.
    ack_delay = 0; bus_if.instr_ready_i = 1'b1;
    applyStimulus(3);
    waitReq("pre_redirect_req");
    redirect = 1'b1; redirect_pc = 32'h0000_0200; applyStimulus(1); redirect = 1'b0;
    checkOutput("redir_ack_addr", bus_if.mem_addr_o, 32'h200);
    checkOutput("redir_ack_req", 32'(bus_if.mem_req_o), 32'd1);
    checkOutput("redir_ack_count", 32'(count), 32'd0);
    applyStimulus(4);

    // Reset landing on an acked request.
    waitReq("pre_reset_req");
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    checkOutput("midreq_rst_req", 32'(bus_if.mem_req_o), 32'd0);
    checkOutput("midreq_rst_count", 32'(count), 32'd0);
    checkOutput("midreq_rst_valid", 32'(bus_if.instr_valid_o), 32'd0);
    waitReq("restart_req");
    checkOutput("restart_addr", bus_if.mem_addr_o, 32'h0);

    // Misaligned redirect near the top of memory: PC+4 wraps to zero.
    bus_if.instr_ready_i = 1'b0;
    applyStimulus(1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; applyStimulus(1); redirect = 1'b0;
    checkOutput("wrap_addr", bus_if.mem_addr_o, 32'hFFFF_FFFC);
    applyStimulus(1);
    checkOutput("wrap_head_pc", bus_if.instr_pc_o, 32'hFFFF_FFFC);
    checkOutput("wrap_head_pc4", bus_if.instr_pc_plus4_o, 32'h0);
    checkOutput("wrap_next_addr", bus_if.mem_addr_o, 32'h0);
    applyStimulus(6);
    bus_if.instr_ready_i = 1'b1;
    applyStimulus(8);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
